dct8_fwd_row: RTL
=================

DCT8_FWD_ROW -- requirements
Module: dct8_fwd_row

Interface
REQ-001 SHALL expose clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL expose reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL expose in_data, input, 25 bits signed: one spatial sample.
REQ-004 SHALL expose in_valid, input, 1 bit: in_data is valid.
REQ-005 SHALL expose in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-006 SHALL expose add, input, 25 bits signed: rounding offset.
REQ-007 SHALL expose shift, input, 4 bits unsigned: arithmetic right-shift amount, 0..15.
REQ-008 SHALL expose out_data, output, 25 bits signed: one transform coefficient.
REQ-009 SHALL expose out_idx, output, 3 bits: coefficient index k of out_data.
REQ-010 SHALL expose out_valid, output, 1 bit: out_data and out_idx are valid.
REQ-011 SHALL expose out_ready, input, 1 bit: downstream accepts the coefficient.

Function
REQ-012 SHALL be the forward 8-point DCT counterpart of the team's pipelined IDCT8 column: X[k] = (sum over n of C[k][n]*x[n] + add) >>> shift.
REQ-013 SHALL use the HEVC 8x8 integer matrix for C: row0 all 64; row1 89,75,50,18,-18,-50,-75,-89; row2 83,36,-36,-83,-83,-36,36,83; row3 75,-18,-89,-50,50,89,18,-75; row4 64,-64,-64,64,64,-64,-64,64; row5 50,-89,18,75,-75,-18,89,-50; row6 36,-83,83,-36,-36,83,-83,36; row7 18,-50,75,-89,89,-75,50,-18.
REQ-014 SHALL implement the FSM states COLLECT, CALC and EMIT.
REQ-015 In COLLECT: in_ready=1; a sample is accepted only when in_valid&&in_ready; it is stored at x[cnt] and cnt increments; on the 8th accept the FSM moves to CALC with k=0.
REQ-016 In CALC: one cycle; in_ready=0, out_valid=0; X[k] is registered into out_data, and k into out_idx; next state is EMIT.
REQ-017 In EMIT: out_valid=1, with out_data and out_idx held stable until out_valid&&out_ready; on that handshake, if k==7 the FSM goes to COLLECT with cnt=0, else k increments and the FSM goes to CALC.
REQ-018 Latency: the first out_valid SHALL occur 2 cycles after the 8th input accept; steady rate is 1 coefficient per 2 cycles with out_ready held high.
REQ-019 add and shift SHALL be sampled in the CALC cycle; changing them between coefficients affects only later coefficients.
REQ-020 Accumulation SHALL be at least 36 bits signed; the shift SHALL be arithmetic; the result SHALL be truncated to the low 25 bits, with no saturation.
REQ-021 in_valid while in CALC or EMIT SHALL be ignored, and no sample is lost because in_ready=0.
REQ-022 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-023 Asserting reset (low) SHALL immediately force state=COLLECT, cnt=0, k=0, out_valid=0, out_data=0, out_idx=0 and x[0..7]=0.
REQ-024 in_ready SHALL be 1 while reset is low and after its release; reset mid-EMIT SHALL discard the partial block.

Configuration
REQ-025 Macro DCT8_PARTIAL_BUTTERFLY_EN defined: X[k] SHALL use even/odd decomposition (e[n]=x[n]+x[7-n], o[n]=x[n]-x[7-n], 4 multiplies per coefficient).
REQ-026 Macro undefined: a direct 8-tap dot product SHALL be used; out_data SHALL be bit-identical in both builds for all inputs.

Structure
REQ-027 Package dct8_pkg SHALL hold the 8x8 coefficient table, the widths (DATA_W=25, ACC_W=36), and the FSM state enum.
REQ-028 A single sub-module dct8_coef_mac (inputs x[0..7], k, add, shift; output the 25-bit coefficient, combinational) SHALL contain the arithmetic and the macro switch.

Verification
REQ-029 DC test: all x=10, add=0, shift=0 -> X[0]=5120, X[1..7]=0, out_idx 0..7 in order.
REQ-030 Impulse test: x0=1, others 0, add=0, shift=0 -> outputs 64,89,83,75,64,50,36,18.
REQ-031 Rounding test: all x=1, add=64, shift=7 -> X[0]=4; with x0=-1, others 0, add=0, shift=1 -> X[1]=-45.
REQ-032 Backpressure test: out_ready low for 5 cycles during EMIT -> out_data/out_idx stable, out_valid=1, in_ready=0, no coefficient is skipped or duplicated.
REQ-033 Reset test: reset low during EMIT k=3 -> out_valid=0 at once; after release, a fresh 8-sample block yields correct X[0..7].
REQ-034 Both builds (macro defined and undefined) SHALL produce identical output on 1000 random blocks (random samples in +/-2^15, random add and shift).

Source files
------------

// File: rtl/dct8_pkg.sv
// dct8_pkg -- shared definitions for the forward 8-point row DCT.
//
// Holds the datapath widths, the HEVC 8x8 integer transform matrix and
// the controller state encoding used by dct8_fwd_row and dct8_coef_mac.
package dct8_pkg;

    localparam int DATA_W = 25;  // sample / coefficient width (signed)
    localparam int ACC_W  = 36;  // accumulator width (signed)
    localparam int COEF_W = 8;   // matrix entry width (signed)
    localparam int N      = 8;   // transform length
    localparam int IDX_W  = 3;   // width of sample / coefficient index

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_CALC,
        ST_EMIT
    } state_t;

    // COEF[k][n]: HEVC forward matrix, row k = output coefficient index.
    localparam logic signed [COEF_W-1:0] COEF [0:N-1][0:N-1] = '{
        '{ 8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64},
        '{ 8'sd89,  8'sd75,  8'sd50,  8'sd18, -8'sd18, -8'sd50, -8'sd75, -8'sd89},
        '{ 8'sd83,  8'sd36, -8'sd36, -8'sd83, -8'sd83, -8'sd36,  8'sd36,  8'sd83},
        '{ 8'sd75, -8'sd18, -8'sd89, -8'sd50,  8'sd50,  8'sd89,  8'sd18, -8'sd75},
        '{ 8'sd64, -8'sd64, -8'sd64,  8'sd64,  8'sd64, -8'sd64, -8'sd64,  8'sd64},
        '{ 8'sd50, -8'sd89,  8'sd18,  8'sd75, -8'sd75, -8'sd18,  8'sd89, -8'sd50},
        '{ 8'sd36, -8'sd83,  8'sd83, -8'sd36, -8'sd36,  8'sd83, -8'sd83,  8'sd36},
        '{ 8'sd18, -8'sd50,  8'sd75, -8'sd89,  8'sd89, -8'sd75,  8'sd50, -8'sd18}
    };

endpackage

// File: rtl/dct8_coef_mac.sv
// dct8_coef_mac -- combinational computation of one DCT coefficient.
//
//   coef = (sum_n COEF[k][n] * x[n] + add) >>> shift, truncated to DATA_W.
//
// Ports:
//   x[0..7]  in   DATA_W signed  buffered spatial samples
//   k        in   IDX_W          coefficient index
//   add      in   DATA_W signed  rounding offset
//   shift    in   4              arithmetic right-shift amount
//   coef     out  DATA_W signed  resulting coefficient
//
// Build option: DCT8_PARTIAL_BUTTERFLY_EN selects the even/odd
// decomposition (4 multiplies); otherwise a direct 8-tap dot product is
// used. Both forms are exact in ACC_W bits, so results are bit-identical.
module dct8_coef_mac
    import dct8_pkg::*;
(
    input  logic signed [DATA_W-1:0] x [N],
    input  logic        [IDX_W-1:0]  k,
    input  logic signed [DATA_W-1:0] add,
    input  logic        [3:0]        shift,
    output logic signed [DATA_W-1:0] coef
);

    logic signed [ACC_W-1:0] acc;

`ifdef DCT8_PARTIAL_BUTTERFLY_EN
    logic signed [ACC_W-1:0] e [N/2];
    logic signed [ACC_W-1:0] o [N/2];

    // Even rows of the matrix are symmetric and odd rows antisymmetric,
    // so only the first half of each row is needed.
    always_comb begin
        acc = ACC_W'(add);
        for (int n = 0; n < N/2; n++) begin
            e[n] = ACC_W'(x[n]) + ACC_W'(x[N-1-n]);
            o[n] = ACC_W'(x[n]) - ACC_W'(x[N-1-n]);
            acc  = acc + ACC_W'(COEF[k][n]) * (k[0] ? o[n] : e[n]);
        end
    end
`else
    // NOTE: blocking '=' is correct here: acc is a combinational running
    // sum, each loop step must see the previous step's value.
    always_comb begin
        acc = ACC_W'(add);
        for (int n = 0; n < N; n++) begin
            acc = acc + ACC_W'(COEF[k][n]) * ACC_W'(x[n]);
        end
    end
`endif

    // Arithmetic shift keeps the sign; the result wraps, no saturation.
    assign coef = DATA_W'(acc >>> shift);

endmodule

// File: rtl/dct8_fwd_row.sv
// dct8_fwd_row -- forward 8-point integer DCT (HEVC matrix), one row.
//
// Collects 8 samples through a valid/ready input, then emits X[0..7] one
// per two cycles through a valid/ready output (CALC registers X[k], EMIT
// holds it until accepted).
//
// Ports:
//   clk        in   1              rising-edge clock
//   reset      in   1              asynchronous reset, active low
//   in_data    in   DATA_W signed  spatial sample
//   in_valid   in   1              in_data valid
//   in_ready   out  1              sample accepted this cycle
//   add        in   DATA_W signed  rounding offset, sampled in CALC
//   shift      in   4              right-shift amount, sampled in CALC
//   out_data   out  DATA_W signed  transform coefficient
//   out_idx    out  IDX_W          coefficient index k
//   out_valid  out  1              out_data/out_idx valid
//   out_ready  in   1              downstream accepts coefficient
//
// Build option: DCT8_PARTIAL_BUTTERFLY_EN (see dct8_coef_mac).
module dct8_fwd_row
    import dct8_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] add,
    input  logic        [3:0]        shift,
    output logic signed [DATA_W-1:0] out_data,
    output logic        [IDX_W-1:0]  out_idx,
    output logic                     out_valid,
    input  logic                     out_ready
);

    state_t                   state;
    state_t                   next_state;
    logic signed [DATA_W-1:0] x [N];
    logic        [IDX_W-1:0]  cnt;
    logic        [IDX_W-1:0]  k;
    logic signed [DATA_W-1:0] mac_out;
    logic                     accept;
    logic                     emit_done;

    assign accept    = in_valid && in_ready;
    assign emit_done = out_valid && out_ready;

    dct8_coef_mac u_mac (
        .x     (x),
        .k     (k),
        .add   (add),
        .shift (shift),
        .coef  (mac_out)
    );

    // NOTE: state registers use non-blocking '<=' so every flop samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            ST_COLLECT: begin
                in_ready = 1'b1;
                if (accept && cnt == LAST_IDX) begin
                    next_state = ST_CALC;
                end
            end
            ST_CALC: begin
                next_state = ST_EMIT;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (emit_done) begin
                    next_state = (k == LAST_IDX) ? ST_COLLECT : ST_CALC;
                end
            end
            default: begin
                next_state = ST_COLLECT;
            end
        endcase
    end

    // NOTE: the sample buffer is cleared by reset on purpose, so a block
    // aborted by reset can never leak stale samples into later results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                x[i] <= '0;
            end
            cnt      <= '0;
            k        <= '0;
            out_data <= '0;
            out_idx  <= '0;
        end else begin
            unique case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        x[cnt] <= in_data;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            k <= '0;
                        end
                    end
                end
                ST_CALC: begin
                    out_data <= mac_out;
                    out_idx  <= k;
                end
                ST_EMIT: begin
                    if (emit_done) begin
                        if (k == LAST_IDX) begin
                            cnt <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
